imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Registered, handshaked immediate generator for the RV32I/RV64I decode stage. Accepts one full instruction word plus its PC per beat. Classifies the format from the opcode, extracts the sign-extended immediate to XLEN, and computes the PC-relative target. Uses a valid/ready interface with a 2-entry skid buffer, so fetch-to-decode runs at full throughput with a registered in_ready, and supports a synchronous flush on redirect.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; immediates are sign-extended to XLEN.
SKID_DEPTH, 2, output buffering entries; fixed at 2 (any other value is a configuration error flagged at elaboration).

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous clear of all buffered beats
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat (registered)
in_ins  in  32  instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  output beat valid
out_ready  in  1  consumer accepts beat
out_fmt  out  3  format: 0 NONE(R), 1 I, 2 S, 3 B, 4 U, 5 J, 7 ILLEGAL
out_imm  out  XLEN  sign-extended immediate
out_target  out  XLEN  PC-relative target
out_pc  out  XLEN  PC passed through

Behaviour:
- Opcode mapping:
  - I: 0010011, 0000011, 1100111, 1110011, 0001111
  - S: 0100011
  - B: 1100011
  - U: 0110111 (LUI), 0010111 (AUIPC)
  - J: 1101111
  - NONE: 0110011
  - Any other opcode gives ILLEGAL with imm=0.
- Immediate extraction (then sign-extended to XLEN):
  - I: ins[31:20]
  - S: {ins[31:25],ins[11:7]}
  - B: {ins[31],ins[7],ins[30:25],ins[11:8],1'b0}
  - U: {ins[31:12],12'b0}
  - J: {ins[31],ins[19:12],ins[20],ins[30:21],1'b0}
  - NONE: imm=0
- Target: pc+imm, modulo 2^XLEN (wraps silently), for B, J and AUIPC. All other formats, including JALR, drive target=0.
- Handshake:
  - A beat transfers on valid&&ready at a rising edge.
  - Latency is 1 cycle: a beat accepted at edge N is presented with out_valid=1 after edge N.
  - With out_ready held high, one beat per cycle, with no bubbles.
  - While out_valid&&!out_ready, all out_* signals stay stable.
- Skid buffer:
  - in_ready=1 when the skid entry is empty.
  - When the output stalls, the 2nd accepted beat parks in the skid entry and in_ready drops on the next cycle.
  - On drain, the skid entry moves to the output register; in_ready rises the following cycle.
  - Output order is FIFO; no beat is ever dropped or duplicated.
- Simultaneous in and out transfer with a full output register and empty skid: the output reloads directly and the skid stays empty.
- flush: both entries are cleared at the edge and out_valid=0 after it. An input beat presented in the flush cycle is discarded. in_ready=1 after the flush edge. flush has priority over accept.
- Reset: out_valid=0, out_fmt=0, out_imm=0, out_target=0, out_pc=0, skid emptied. in_ready=0 while rst=1 and 1 on the first cycle after release. Reset mid-transfer discards all beats.

Optional Feature:
IMMGEN_TARGET_EN
- Defined: the XLEN adder is instantiated and out_target behaves as specified above.
- Undefined: no adder; out_target is tied to 0 for every format. The port remains for interface stability.

Decomposition:
- Shared package imm_pkg:
  - fmt enum: FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILLEGAL
  - 7-bit opcode constants: OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_FENCE, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP
- Sub-module imm_extract: purely combinational; takes ins and pc and returns fmt/imm/target. The top handles only the handshake, skid and flush.

Test Plan:
- XLEN=32, ins 0x00128293 pc 0x0000000C, out_ready=1 -> next cycle out_fmt=1, out_imm=0x00000001, out_target=0, out_pc=0x0C; then ins 0x001E8E93 pc 0x7C -> imm 1, pc 0x7C.
- ins 0xFE000EE3 (beq -4) pc 0x100 -> fmt=3, imm=0xFFFFFFFC, target=0xFC (0 if IMMGEN_TARGET_EN undefined); ins 0x001000EF (jal 2048) pc 0x40 -> fmt=5, imm=0x800, target=0x840.
- XLEN=64, ins 0x800000B7 (lui) -> fmt=4, imm=0xFFFFFFFF80000000, target=0; ins 0x00000000 -> fmt=7, imm=0.
- Backpressure: stream 4 beats with out_ready=0 -> 2 accepted, in_ready=0 from the cycle after the 2nd; raise out_ready -> all 4 emerge in order with no loss or duplication and outputs stable during the stall.
- Flush with 2 beats buffered and in_valid=1 -> out_valid=0 next cycle, in_ready=1, the flush-cycle beat never appears.
- rst asserted mid-stream -> all outputs 0, in_ready=0 during reset and 1 the cycle after release; full throughput (1 beat/cycle) with out_ready=1 over 16 random beats.

Source files
------------

// File: rtl/imm_pkg.sv
// imm_pkg: shared types and constants for the immediate generator.
//   fmt_e       - instruction format class presented on out_fmt
//   OPC_*       - 7-bit RV32I/RV64I major opcodes
//   opc_to_fmt  - maps a major opcode to its format class
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE    = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_ILLEGAL = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  function automatic fmt_e opc_to_fmt(input logic [6:0] opc);
    fmt_e f;
    case (opc)
      OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_FENCE: f = FMT_I;
      OPC_STORE:         f = FMT_S;
      OPC_BRANCH:        f = FMT_B;
      OPC_LUI, OPC_AUIPC: f = FMT_U;
      OPC_JAL:           f = FMT_J;
      OPC_OP:            f = FMT_NONE;
      default:           f = FMT_ILLEGAL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_extract.sv
// imm_extract: combinational format decode, immediate extraction and
// PC-relative target computation for one instruction word.
//   ins_i    [31:0]     instruction word
//   pc_i     [XLEN-1:0] instruction address
//   fmt_o               format class
//   imm_o    [XLEN-1:0] sign-extended immediate (0 for NONE/ILLEGAL)
//   target_o [XLEN-1:0] pc+imm for B, J and AUIPC, else 0
// Optional macro IMMGEN_TARGET_EN: when undefined no adder is built and
// target_o is always 0.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     ins_i,
  input  logic [XLEN-1:0] pc_i,
  output fmt_e            fmt_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] target_o
);

  logic [31:0] imm32_s;

  // Format decode and raw 32-bit immediate assembly.
  always_comb begin
    fmt_o   = opc_to_fmt(ins_i[6:0]);
    imm32_s = 32'd0;
    case (fmt_o)
      FMT_I:   imm32_s = {{20{ins_i[31]}}, ins_i[31:20]};
      FMT_S:   imm32_s = {{20{ins_i[31]}}, ins_i[31:25], ins_i[11:7]};
      FMT_B:   imm32_s = {{19{ins_i[31]}}, ins_i[31], ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0};
      FMT_U:   imm32_s = {ins_i[31:12], 12'd0};
      FMT_J:   imm32_s = {{11{ins_i[31]}}, ins_i[31], ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0};
      default: imm32_s = 32'd0;
    endcase
    // Signed size cast replicates bit 31 up to XLEN.
    imm_o = XLEN'($signed(imm32_s));
  end

`ifdef IMMGEN_TARGET_EN
  logic pc_rel_s;

  // JALR is I-format and deliberately excluded: its base is rs1, not pc.
  always_comb begin
    pc_rel_s = (fmt_o == FMT_B) || (fmt_o == FMT_J) || (ins_i[6:0] == OPC_AUIPC);
    if (pc_rel_s) begin
      target_o = pc_i + imm_o;
    end else begin
      target_o = {XLEN{1'b0}};
    end
  end
`else
  logic unused_pc_s;

  // Without the adder the target port is held at zero.
  always_comb begin
    unused_pc_s = ^pc_i;
    target_o    = {XLEN{1'b0}};
  end
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered, valid/ready immediate generator with a
// 2-entry output buffer (output register + skid entry).
//   clk, rst, flush                 clock, sync active-high reset, sync clear
//   in_valid/in_ready/in_ins/in_pc  input beat (in_ready is registered)
//   out_valid/out_ready             output handshake
//   out_fmt/out_imm/out_target/out_pc  registered decoded beat
// Optional macro IMMGEN_TARGET_EN enables the pc+imm adder in imm_extract.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SKID_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ins,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc
);

  if (SKID_DEPTH != 2) begin : g_bad_skid_depth
    $error("imm_gen_pipe: SKID_DEPTH must be 2");
  end
  if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  fmt_e            new_fmt_s;
  logic [XLEN-1:0] new_imm_s;
  logic [XLEN-1:0] new_tgt_s;
  logic            in_fire_s;
  logic            out_fire_s;

  logic            out_valid_q, out_valid_d;
  logic [2:0]      out_fmt_q, out_fmt_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  logic [XLEN-1:0] out_tgt_q, out_tgt_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic            skid_valid_q, skid_valid_d;
  logic [2:0]      skid_fmt_q, skid_fmt_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  logic [XLEN-1:0] skid_tgt_q, skid_tgt_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic            in_ready_q, in_ready_d;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .ins_i    (in_ins),
    .pc_i     (in_pc),
    .fmt_o    (new_fmt_s),
    .imm_o    (new_imm_s),
    .target_o (new_tgt_s)
  );

  assign in_fire_s  = in_valid && in_ready_q;
  assign out_fire_s = out_valid_q && out_ready;

  // Buffer steering: the output register refills from the skid entry
  // first (FIFO order), otherwise directly from the input; the skid entry
  // only captures a beat while the output register is stalled.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_fmt_d    = out_fmt_q;
    out_imm_d    = out_imm_q;
    out_tgt_d    = out_tgt_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_fmt_d   = skid_fmt_q;
    skid_imm_d   = skid_imm_q;
    skid_tgt_d   = skid_tgt_q;
    skid_pc_d    = skid_pc_q;
    if (!out_valid_q || out_fire_s) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_fmt_d    = skid_fmt_q;
        out_imm_d    = skid_imm_q;
        out_tgt_d    = skid_tgt_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = 1'b0;
      end else if (in_fire_s) begin
        out_valid_d = 1'b1;
        out_fmt_d   = new_fmt_s;
        out_imm_d   = new_imm_s;
        out_tgt_d   = new_tgt_s;
        out_pc_d    = in_pc;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      if (in_fire_s) begin
        skid_valid_d = 1'b1;
        skid_fmt_d   = new_fmt_s;
        skid_imm_d   = new_imm_s;
        skid_tgt_d   = new_tgt_s;
        skid_pc_d    = in_pc;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
    // Registered ready: accept next cycle only if the skid entry will be free.
    in_ready_d = !skid_valid_d;
  end

  // State registers with reset and flush; flush drops both entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_fmt_q    <= 3'd0;
      out_imm_q    <= {XLEN{1'b0}};
      out_tgt_q    <= {XLEN{1'b0}};
      out_pc_q     <= {XLEN{1'b0}};
      skid_valid_q <= 1'b0;
      skid_fmt_q   <= 3'd0;
      skid_imm_q   <= {XLEN{1'b0}};
      skid_tgt_q   <= {XLEN{1'b0}};
      skid_pc_q    <= {XLEN{1'b0}};
      in_ready_q   <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_fmt_q    <= out_fmt_d;
      out_imm_q    <= out_imm_d;
      out_tgt_q    <= out_tgt_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_imm_q   <= skid_imm_d;
      skid_tgt_q   <= skid_tgt_d;
      skid_pc_q    <= skid_pc_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_fmt    = out_fmt_q;
  assign out_imm    = out_imm_q;
  assign out_target = out_tgt_q;
  assign out_pc     = out_pc_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: one XLEN=32 and one XLEN=64 instance share stimulus;
// a scoreboard queue mirrors the beats held inside the block.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_ins;
  logic [63:0] in_pc;
  logic [31:0] in_pc32;
  logic        out_ready;

  logic        in_ready32, out_valid32;
  logic [2:0]  out_fmt32;
  logic [31:0] out_imm32, out_target32, out_pc32;
  logic        in_ready64, out_valid64;
  logic [2:0]  out_fmt64;
  logic [63:0] out_imm64, out_target64, out_pc64;

  assign in_pc32 = in_pc[31:0];

  imm_gen_pipe #(.XLEN(32), .SKID_DEPTH(2)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_ins(in_ins), .in_pc(in_pc32),
    .out_valid(out_valid32), .out_ready(out_ready), .out_fmt(out_fmt32),
    .out_imm(out_imm32), .out_target(out_target32), .out_pc(out_pc32)
  );

  imm_gen_pipe #(.XLEN(64), .SKID_DEPTH(2)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_ins(in_ins), .in_pc(in_pc),
    .out_valid(out_valid64), .out_ready(out_ready), .out_fmt(out_fmt64),
    .out_imm(out_imm64), .out_target(out_target64), .out_pc(out_pc64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [63:0] pc;
    logic        rel;
  } item_t;

  item_t q[$];
  int    checks = 0;
  int    errors = 0;
  logic  last_rst = 1'b0;

  // Reference model computed at 64 bits; the 32-bit view is the low half.
  function automatic item_t model(input logic [31:0] ins, input logic [63:0] pc);
    item_t it;
    logic [31:0] i32;
    it.fmt = 3'd7;
    it.rel = 1'b0;
    i32 = 32'd0;
    case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
        it.fmt = 3'd1; i32 = {{20{ins[31]}}, ins[31:20]};
      end
      7'b0100011: begin it.fmt = 3'd2; i32 = {{20{ins[31]}}, ins[31:25], ins[11:7]}; end
      7'b1100011: begin
        it.fmt = 3'd3; it.rel = 1'b1;
        i32 = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'b0110111: begin it.fmt = 3'd4; i32 = {ins[31:12], 12'd0}; end
      7'b0010111: begin it.fmt = 3'd4; it.rel = 1'b1; i32 = {ins[31:12], 12'd0}; end
      7'b1101111: begin
        it.fmt = 3'd5; it.rel = 1'b1;
        i32 = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'b0110011: begin it.fmt = 3'd0; i32 = 32'd0; end
      default:    begin it.fmt = 3'd7; i32 = 32'd0; end
    endcase
    it.imm = {{32{i32[31]}}, i32};
    it.pc  = pc;
    it.tgt = 64'd0;
`ifdef IMMGEN_TARGET_EN
    if (it.rel) it.tgt = pc + it.imm;
`endif
    return it;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare both instances against the scoreboard after an edge.
  task automatic check_state();
    item_t e;
    logic  exp_rdy;
    exp_rdy = last_rst ? 1'b0 : (q.size() < 2);
    chk("in_ready32", {63'd0, in_ready32}, {63'd0, exp_rdy});
    chk("in_ready64", {63'd0, in_ready64}, {63'd0, exp_rdy});
    chk("out_valid32", {63'd0, out_valid32}, {63'd0, q.size() != 0});
    chk("out_valid64", {63'd0, out_valid64}, {63'd0, q.size() != 0});
    if (q.size() != 0) begin
      e = q[0];
      chk("fmt32", {61'd0, out_fmt32}, {61'd0, e.fmt});
      chk("imm32", {32'd0, out_imm32}, {32'd0, e.imm[31:0]});
      chk("target32", {32'd0, out_target32}, {32'd0, e.tgt[31:0]});
      chk("pc32", {32'd0, out_pc32}, {32'd0, e.pc[31:0]});
      chk("fmt64", {61'd0, out_fmt64}, {61'd0, e.fmt});
      chk("imm64", out_imm64, e.imm);
      chk("target64", out_target64, e.tgt);
      chk("pc64", out_pc64, e.pc);
    end else if (last_rst) begin
      chk("rst_fmt", {58'd0, out_fmt32, out_fmt64}, 64'd0);
      chk("rst_imm", out_imm64 | {32'd0, out_imm32}, 64'd0);
      chk("rst_target", out_target64 | {32'd0, out_target32}, 64'd0);
      chk("rst_pc", out_pc64 | {32'd0, out_pc32}, 64'd0);
    end
  endtask

  // One clock: inputs are already set; update the scoreboard at the edge.
  task automatic step();
    logic in_fire, out_fire;
    in_fire  = in_valid && in_ready32;
    out_fire = out_valid32 && out_ready;
    @(posedge clk);
    if (rst) begin
      q.delete();
      last_rst = 1'b1;
    end else begin
      last_rst = 1'b0;
      if (flush) begin
        q.delete();
      end else begin
        if (out_fire && q.size() != 0) void'(q.pop_front());
        if (in_fire) q.push_back(model(in_ins, in_pc));
      end
    end
    @(negedge clk);
    check_state();
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() != 0; i++) step();
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  logic [31:0] dir_ins [12];
  logic [63:0] dir_pc  [12];
  logic [6:0]  opcs    [12];
  int          k;
  logic        acc;

  initial begin
    dir_ins[0]  = 32'h00128293; dir_pc[0]  = 64'h0C;
    dir_ins[1]  = 32'h001E8E93; dir_pc[1]  = 64'h7C;
    dir_ins[2]  = 32'hFE000EE3; dir_pc[2]  = 64'h100;
    dir_ins[3]  = 32'h001000EF; dir_pc[3]  = 64'h40;
    dir_ins[4]  = 32'h800000B7; dir_pc[4]  = 64'h200;
    dir_ins[5]  = 32'h00000000; dir_pc[5]  = 64'h204;
    dir_ins[6]  = 32'hFE112E23; dir_pc[6]  = 64'h208;
    dir_ins[7]  = 32'hFFFFF297; dir_pc[7]  = 64'h10;
    dir_ins[8]  = 32'h008080E7; dir_pc[8]  = 64'h20;
    dir_ins[9]  = 32'h002081B3; dir_pc[9]  = 64'h24;
    dir_ins[10] = 32'h001000EF; dir_pc[10] = 64'h0000_0001_FFFF_FFF0;
    dir_ins[11] = 32'h80000063; dir_pc[11] = 64'h0;
    opcs[0] = 7'b0010011; opcs[1] = 7'b0000011; opcs[2]  = 7'b1100111; opcs[3]  = 7'b1110011;
    opcs[4] = 7'b0001111; opcs[5] = 7'b0100011; opcs[6]  = 7'b1100011; opcs[7]  = 7'b0110111;
    opcs[8] = 7'b0010111; opcs[9] = 7'b1101111; opcs[10] = 7'b0110011; opcs[11] = 7'b1010101;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ins = 32'd0; in_pc = 64'd0;
    @(negedge clk);
    step(); step();
    rst = 1'b0;
    step();

    // Directed decode, back to back with out_ready high.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_ins = dir_ins[i]; in_pc = dir_pc[i];
      step();
    end
    in_valid = 1'b0;
    step(); step();

    // Backpressure: four beats against a stalled consumer.
    out_ready = 1'b0; k = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_ins = dir_ins[k + 2]; in_pc = 64'h1000 + 64'(4 * k);
      acc = in_ready32;
      step();
      if (acc) k++;
    end
    chk("bp_accepted", 64'(k), 64'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && k < 4; i++) begin
      in_valid = 1'b1; in_ins = dir_ins[k + 2]; in_pc = 64'h1000 + 64'(4 * k);
      acc = in_ready32;
      step();
      if (acc) k++;
    end
    in_valid = 1'b0;
    chk("bp_all_sent", 64'(k), 64'd4);
    drain();

    // Flush with two and with one beat buffered, new beat offered alongside.
    for (int nb = 2; nb >= 1; nb--) begin
      out_ready = 1'b0;
      for (int i = 0; i < nb; i++) begin
        in_valid = 1'b1; in_ins = dir_ins[i + 6]; in_pc = 64'h2000 + 64'(4 * i);
        step();
      end
      flush = 1'b1; in_ins = dir_ins[3]; in_pc = 64'h3000;
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step(); step(); step();
    end

    // Reset in the middle of a stream.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_ins = dir_ins[i]; in_pc = 64'h4000 + 64'(4 * i);
      step();
    end
    out_ready = 1'b0;
    in_ins = dir_ins[4]; step();
    rst = 1'b1; in_ins = dir_ins[5];
    step(); step();
    rst = 1'b0; in_valid = 1'b0;
    step();

    // Full throughput over 16 random beats.
    out_ready = 1'b1; k = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_ins = $urandom();
      in_ins[6:0] = opcs[$urandom_range(0, 11)];
      in_pc = {32'($urandom()), 32'($urandom())};
      acc = in_ready32;
      step();
      if (acc) k++;
    end
    in_valid = 1'b0;
    chk("thru_accepted", 64'(k), 64'd16);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
